// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, halt FSM states and defaults for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int NSTAGE_DEF = 5;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;
    localparam int STG_MA = 3;
    localparam int STG_WB = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/control bundle between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF
) ();

    logic [NSTAGE-1:0]        stall_req;
    logic [NSTAGE*NSTAGE-1:0] flush_mask;
    logic                     halt_req;
    logic [NSTAGE-1:0]        pipe_stall;
    logic [NSTAGE-1:0]        pipe_flush;
    logic                     fetch_hold;
    logic                     halt_ack;
    logic                     stall_timeout;
    logic [31:0]              perf_cycles;
    logic [31:0]              perf_stalls;
    logic [31:0]              perf_flushes;

    // Stage side: raises requests, consumes per-stage controls.
    modport master (
        output stall_req, flush_mask, halt_req,
        input  pipe_stall, pipe_flush, fetch_hold, halt_ack, stall_timeout,
        input  perf_cycles, perf_stalls, perf_flushes
    );

    modport slave (
        input  stall_req, flush_mask, halt_req,
        output pipe_stall, pipe_flush, fetch_hold, halt_ack, stall_timeout,
        output perf_cycles, perf_stalls, perf_flushes
    );

endinterface

// File: rtl/pipe_stall_watchdog.sv
// rtl/pipe_stall_watchdog.sv - saturating consecutive-stall counter with sticky timeout flag
module pipe_stall_watchdog #(
    parameter int STALL_LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    output logic timeout_o
);

    generate
        if (STALL_LIMIT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, stall_i};
            assign timeout_o     = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(STALL_LIMIT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          flag_q, flag_d;

            always_comb begin
                cnt_d = '0;
                if (stall_i) begin
                    cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
                end
                // Flag sets on the same edge the count reaches the limit.
                flag_d = flag_q | (cnt_d == LIMIT);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    flag_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    flag_q <= flag_d;
                end
            end

            assign timeout_o = flag_q;
        end
    endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with halt/drain FSM and stall watchdog
// Optional perf counters built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE      = NSTAGE_DEF,
    parameter int STALL_LIMIT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_ctrl_if.slave   bus
);

    localparam int DW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(NSTAGE - 1);

    halt_state_t       state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [NSTAGE-1:0] flush_req;
    logic [NSTAGE-1:0] stall_any;
    logic [NSTAGE-1:0] flush_o;
    logic [NSTAGE-1:0] stall_o;
    logic              in_drain;
    logic              timeout;

    // Only upstream-facing entries count: requester k affects stages j<k.
    always_comb begin
        flush_req = '0;
        stall_any = '0;
        for (int j = 0; j < NSTAGE; j++) begin
            for (int k = j + 1; k < NSTAGE; k++) begin
                flush_req[j] = flush_req[j] | bus.flush_mask[k*NSTAGE + j];
                stall_any[j] = stall_any[j] | bus.stall_req[k];
            end
        end
    end

    assign in_drain = (state_q == DRAIN);

    always_comb begin
        flush_o         = flush_req;
        flush_o[STG_IF] = flush_req[STG_IF] | in_drain;
        stall_o         = stall_any & ~flush_o;
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!bus.halt_req) begin
                    state_d = RUN;
                end else if (!stall_any[STG_IF]) begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (drain_cnt_d == DRAIN_LAST) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!bus.halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    pipe_stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (|bus.stall_req),
        .timeout_o (timeout)
    );

    // Every output reads 0 while reset is held.
    assign bus.pipe_flush    = rst_n ? flush_o : '0;
    assign bus.pipe_stall    = rst_n ? stall_o : '0;
    assign bus.fetch_hold    = rst_n & (state_q != RUN);
    assign bus.halt_ack      = rst_n & (state_q == HALTED);
    assign bus.stall_timeout = rst_n & timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q, perf_flushes_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (|stall_o) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
            if ((|flush_o) && !in_drain) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign bus.perf_cycles  = rst_n ? perf_cycles_q  : '0;
    assign bus.perf_stalls  = rst_n ? perf_stalls_q  : '0;
    assign bus.perf_flushes = rst_n ? perf_flushes_q : '0;
`else
    assign bus.perf_cycles  = '0;
    assign bus.perf_stalls  = '0;
    assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (NSTAGE=5, STALL_LIMIT=8)
module tb_pipe_ctrl;

    localparam int NS  = 5;
    localparam int LIM = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_ctrl_if #(.NSTAGE(NS)) bus ();

    pipe_ctrl #(
        .NSTAGE      (NS),
        .STALL_LIMIT (LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NS-1:0] model_flush(input logic [NS*NS-1:0] m, input logic drain);
        logic [NS-1:0] r;
        r = '0;
        for (int k = 0; k < NS; k++)
            for (int j = 0; j < k; j++)
                if (m[k*NS + j]) r[j] = 1'b1;
        if (drain) r[0] = 1'b1;
        return r;
    endfunction

    function automatic logic [NS-1:0] model_stall(input logic [NS-1:0] req, input logic [NS-1:0] fl);
        logic [NS-1:0] r;
        for (int j = 0; j < NS; j++)
            r[j] = ((req >> (j + 1)) != 0) && !fl[j];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.stall_req  = '0;
        bus.flush_mask = '0;
        bus.halt_req   = 1'b0;
        rst_n          = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [NS+6-1:0] outs;
        rst_n          = 1'b0;
        bus.stall_req  = '1;
        bus.flush_mask = '1;
        bus.halt_req   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            outs = {bus.pipe_stall, bus.pipe_flush[0], bus.fetch_hold, bus.halt_ack,
                    bus.stall_timeout, |bus.perf_cycles, |bus.perf_stalls};
            n_checks++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs_zero: got %b expected 0", outs);
            end
        end
        bus.stall_req  = '0;
        bus.flush_mask = '0;
        bus.halt_req   = 1'b0;
        step();
        rst_n = 1'b1;
        #3;
        n_checks++;
        if ({bus.fetch_hold, bus.halt_ack, bus.stall_timeout, bus.pipe_flush} !== '0) begin
            n_fail++;
            $display("FAIL reset_state_run: got hold=%b ack=%b tmo=%b flush=%b expected all 0",
                     bus.fetch_hold, bus.halt_ack, bus.stall_timeout, bus.pipe_flush);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        bus.stall_req = 5'b00010;
        #3;
        n_checks++;
        if (bus.pipe_stall !== 5'b00001 || bus.pipe_flush !== 5'b00000) begin
            n_fail++;
            $display("FAIL id_stall: got stall=%b flush=%b expected 00001/00000",
                     bus.pipe_stall, bus.pipe_flush);
        end
        step();
        bus.flush_mask[2*NS +: NS] = 5'b00011;
        #3;
        n_checks++;
        if (bus.pipe_flush !== 5'b00011 || bus.pipe_stall !== 5'b00000) begin
            n_fail++;
            $display("FAIL flush_override: got stall=%b flush=%b expected 00000/00011",
                     bus.pipe_stall, bus.pipe_flush);
        end
        // Self and downstream bits must be ignored.
        bus.stall_req  = 5'b00001;
        bus.flush_mask = '0;
        bus.flush_mask[2*NS +: NS] = 5'b11100;
        #1;
        n_checks++;
        if (bus.pipe_flush !== 5'b00000 || bus.pipe_stall !== 5'b00000) begin
            n_fail++;
            $display("FAIL ignored_bits: got stall=%b flush=%b expected 00000/00000",
                     bus.pipe_stall, bus.pipe_flush);
        end
        bus.stall_req  = '0;
        bus.flush_mask = '0;
    endtask

    task automatic test_halt();
        do_reset();
        bus.halt_req = 1'b1;
        #3;
        n_checks++;
        if (bus.fetch_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_t0_hold: got %b expected 0", bus.fetch_hold);
        end
        step();
        for (int c = 1; c <= 6; c++) begin
            #3;
            n_checks++;
            if (bus.fetch_hold !== 1'b1 || bus.halt_ack !== (c >= 5) || bus.pipe_flush[0] !== (c < 5)) begin
                n_fail++;
                $display("FAIL halt_seq t+%0d: got hold=%b ack=%b flush0=%b expected 1/%b/%b",
                         c, bus.fetch_hold, bus.halt_ack, bus.pipe_flush[0], c >= 5, c < 5);
            end
            step();
        end
        bus.halt_req = 1'b0;
        #3;
        n_checks++;
        if (bus.halt_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_ack_held: got %b expected 1", bus.halt_ack);
        end
        step();
        #3;
        n_checks++;
        if (bus.halt_ack !== 1'b0 || bus.fetch_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_release: got ack=%b hold=%b expected 0/0", bus.halt_ack, bus.fetch_hold);
        end

        do_reset();
        bus.halt_req = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            bus.stall_req = (c == 2 || c == 3) ? 5'b01000 : 5'b00000;
            #3;
            n_checks++;
            if (bus.halt_ack !== (c >= 7) || bus.fetch_hold !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_ma_stall t+%0d: got ack=%b hold=%b expected %b/1",
                         c, bus.halt_ack, bus.fetch_hold, c >= 7);
            end
            step();
        end

        do_reset();
        bus.halt_req = 1'b1;
        step();
        step();
        bus.halt_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            #3;
            n_checks++;
            if (bus.halt_ack !== 1'b0 || bus.fetch_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_abort c%0d: got ack=%b hold=%b expected 0/0",
                         c, bus.halt_ack, bus.fetch_hold);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.stall_req = 5'b01000;
        for (int i = 1; i <= LIM + 3; i++) begin
            if (i > LIM) bus.stall_req = '0;
            step();
            #3;
            n_checks++;
            if (bus.stall_timeout !== (i >= LIM)) begin
                n_fail++;
                $display("FAIL wdog_trip edge%0d: got %b expected %b", i, bus.stall_timeout, i >= LIM);
            end
        end
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            bus.stall_req = (i == 8) ? 5'b00000 : 5'b01000;
            step();
            #3;
            n_checks++;
            if (bus.stall_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_gap edge%0d: got %b expected 0", i, bus.stall_timeout);
            end
        end
        bus.stall_req = '0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        bus.stall_req = 5'b10000;
        for (int i = 0; i < LIM; i++) step();
        bus.stall_req = '0;
        bus.halt_req  = 1'b1;
        step();
        step();
        #3;
        n_checks++;
        if (bus.stall_timeout !== 1'b1 || bus.fetch_hold !== 1'b1 || bus.halt_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_drain: got tmo=%b hold=%b ack=%b expected 1/1/0",
                     bus.stall_timeout, bus.fetch_hold, bus.halt_ack);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #3;
        n_checks++;
        if (bus.stall_timeout !== 1'b0 || bus.fetch_hold !== 1'b0 || bus.halt_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run: got tmo=%b hold=%b ack=%b expected 0/0/0",
                     bus.stall_timeout, bus.fetch_hold, bus.halt_ack);
        end
        bus.halt_req = 1'b0;
    endtask

    task automatic test_perf();
        logic [31:0] ec, es, ef;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.stall_req  = (c == 1 || c == 3 || c == 5) ? 5'b00010 : 5'b00000;
            bus.flush_mask = '0;
            if (c == 6 || c == 8) bus.flush_mask[2*NS +: NS] = 5'b00011;
            step();
        end
        bus.stall_req  = '0;
        bus.flush_mask = '0;
`ifdef PIPE_CTRL_PERF_EN
        ec = 32'd10; es = 32'd3; ef = 32'd2;
`else
        ec = 32'd0; es = 32'd0; ef = 32'd0;
`endif
        #3;
        n_checks++;
        if (bus.perf_cycles !== ec || bus.perf_stalls !== es || bus.perf_flushes !== ef) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     bus.perf_cycles, bus.perf_stalls, bus.perf_flushes, ec, es, ef);
        end
    endtask

    task automatic test_random();
        logic [NS-1:0] ef, es;
        int  run_len;
        logic tmo_exp;
        int  cyc, nst, nfl;
        logic [31:0] pc, ps, pf;
        run_len = 0; tmo_exp = 1'b0; cyc = 0; nst = 0; nfl = 0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            bus.stall_req  = ($urandom_range(0, 3) != 0) ? NS'($urandom) : '0;
            bus.flush_mask = ($urandom_range(0, 2) == 0) ? (NS*NS)'($urandom & $urandom & $urandom) : '0;
            ef = model_flush(bus.flush_mask, 1'b0);
            es = model_stall(bus.stall_req, ef);
            #3;
            n_checks++;
            if (bus.pipe_flush !== ef || bus.pipe_stall !== es || bus.stall_timeout !== tmo_exp) begin
                n_fail++;
                $display("FAIL random c%0d req=%b: got flush=%b stall=%b tmo=%b expected %b/%b/%b",
                         c, bus.stall_req, bus.pipe_flush, bus.pipe_stall, bus.stall_timeout,
                         ef, es, tmo_exp);
            end
            step();
            run_len = (bus.stall_req != 0) ? run_len + 1 : 0;
            if (run_len >= LIM) tmo_exp = 1'b1;
            cyc++;
            if (es != 0) nst++;
            if (ef != 0) nfl++;
        end
        bus.stall_req  = '0;
        bus.flush_mask = '0;
`ifdef PIPE_CTRL_PERF_EN
        pc = 32'(cyc); ps = 32'(nst); pf = 32'(nfl);
`else
        pc = 32'd0; ps = 32'd0; pf = 32'd0;
`endif
        #3;
        n_checks++;
        if (bus.perf_cycles !== pc || bus.perf_stalls !== ps || bus.perf_flushes !== pf) begin
            n_fail++;
            $display("FAIL random_perf: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     bus.perf_cycles, bus.perf_stalls, bus.perf_flushes, pc, ps, pf);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.stall_req  = '0;
        bus.flush_mask = '0;
        bus.halt_req   = 1'b0;
        test_reset();
        test_stall_flush();
        test_halt();
        test_watchdog();
        test_reset_mid_drain();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
